// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states, change codes
// and coin values expressed in 5-unit steps.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam logic [1:0] NONE    = 2'b00;
  localparam logic [1:0] FIVE    = 2'b01;
  localparam logic [1:0] TEN     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam logic [1:0] COIN5_VAL  = 2'd1;
  localparam logic [1:0] COIN10_VAL = 2'd2;

  // Amount owed for a change code, in 5-unit steps.
  function automatic logic [1:0] change_units(input logic [1:0] code);
    logic [1:0] units;
    case (code)
      FIVE:    units = COIN5_VAL;
      TEN:     units = COIN10_VAL;
      default: units = 2'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/change_dispenser_stock_counter.sv
// Saturating coin inventory counter; a simultaneous increment and decrement
// cancel out, and the count never wraps in either direction.
module stock_counter #(
  parameter int          W    = 8,
  parameter int unsigned INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         srst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  // Inventory register: load on reset, otherwise saturating up/down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= W'(INIT);
    end else if (srst) begin
      count <= W'(INIT);
    end else if (inc && !dec) begin
      if (count != {W{1'b1}}) begin
        count <= count + W'(1);
      end
    end else if (dec && !inc) begin
      if (count != {W{1'b0}}) begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays 5 or 10 units from two coin hoppers with a
// request/acknowledge handshake, tracks inventory and flags hopper jams.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int STOCK_W = 8,
  parameter int INIT5   = 10,
  parameter int INIT10  = 10,
  parameter int ACK_TMO = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vend,
  input  logic [1:0]         change,
  input  logic               hop_ack,
  input  logic               refill5,
  input  logic               refill10,
  input  logic               clr_jam,
  output logic               coin5_req,
  output logic               coin10_req,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic               overrun,
  output logic               bad_code,
  output logic               jam,
  output logic [STOCK_W-1:0] stock5,
  output logic [STOCK_W-1:0] stock10
);

  localparam int TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  state_e           state_r;
  logic [1:0]       rst_sync_r;
  logic             srst_s;
  logic [1:0]       rem_r;
  logic             first_r;
  logic [TMO_W-1:0] tmo_r;
  logic             coin5_req_r;
  logic             coin10_req_r;
  logic             busy_r;
  logic             done_r;
  logic             short_r;
  logic             overrun_r;
  logic             bad_code_r;
  logic             jam_r;
  logic             ack_s;
  logic             dec5_s;
  logic             dec10_s;
  logic             feasible_s;

  assign coin5_req  = coin5_req_r;
  assign coin10_req = coin10_req_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign short      = short_r;
  assign overrun    = overrun_r;
  assign bad_code   = bad_code_r;
  assign jam        = jam_r;

  // Reset release synchroniser; logic stays in reset until two edges have passed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign srst_s  = ~rst_sync_r[1];
  assign ack_s   = (state_r == ST_REQ) && hop_ack;
  assign dec5_s  = ack_s && coin5_req_r;
  assign dec10_s = ack_s && coin10_req_r;

  // Can the outstanding amount be paid from current stock at all.
  always_comb begin
    feasible_s = 1'b0;
    case (rem_r)
      COIN10_VAL: feasible_s = (stock10 != {STOCK_W{1'b0}}) || (stock5 > STOCK_W'(1));
      COIN5_VAL:  feasible_s = (stock5 != {STOCK_W{1'b0}});
      default:    feasible_s = 1'b0;
    endcase
  end

  stock_counter #(.W(STOCK_W), .INIT(INIT5)) u_stock5 (
    .clk   (clk),
    .rst   (rst),
    .srst  (srst_s),
    .inc   (refill5),
    .dec   (dec5_s),
    .count (stock5)
  );

  stock_counter #(.W(STOCK_W), .INIT(INIT10)) u_stock10 (
    .clk   (clk),
    .rst   (rst),
    .srst  (srst_s),
    .inc   (refill10),
    .dec   (dec10_s),
    .count (stock10)
  );

  // Dispense FSM with all status outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      rem_r        <= 2'd0;
      first_r      <= 1'b0;
      tmo_r        <= {TMO_W{1'b0}};
      coin5_req_r  <= 1'b0;
      coin10_req_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      short_r      <= 1'b0;
      overrun_r    <= 1'b0;
      bad_code_r   <= 1'b0;
      jam_r        <= 1'b0;
    end else if (srst_s) begin
      state_r      <= ST_IDLE;
      rem_r        <= 2'd0;
      first_r      <= 1'b0;
      tmo_r        <= {TMO_W{1'b0}};
      coin5_req_r  <= 1'b0;
      coin10_req_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      short_r      <= 1'b0;
      overrun_r    <= 1'b0;
      bad_code_r   <= 1'b0;
      jam_r        <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      short_r    <= 1'b0;
      bad_code_r <= 1'b0;
      overrun_r  <= vend && (state_r != ST_IDLE);
      // A jam raised below in the same cycle overrides this clear.
      if (clr_jam) begin
        jam_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (vend) begin
            if ((change == FIVE) || (change == TEN)) begin
              rem_r   <= change_units(change);
              first_r <= 1'b1;
              busy_r  <= 1'b1;
              state_r <= ST_SELECT;
            end else if (change == ILLEGAL) begin
              bad_code_r <= 1'b1;
            end
          end
        end
        ST_SELECT: begin
          if (first_r && (jam_r || !feasible_s)) begin
            short_r <= 1'b1;
            state_r <= ST_FAULT;
          end else begin
            first_r <= 1'b0;
            tmo_r   <= {TMO_W{1'b0}};
            state_r <= ST_REQ;
            if ((rem_r == COIN10_VAL) && (stock10 != {STOCK_W{1'b0}})) begin
              coin10_req_r <= 1'b1;
            end else begin
              coin5_req_r <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (hop_ack) begin
            coin5_req_r  <= 1'b0;
            coin10_req_r <= 1'b0;
            rem_r        <= rem_r - (coin10_req_r ? COIN10_VAL : COIN5_VAL);
            state_r      <= ST_RELEASE;
          end else if (tmo_r == TMO_LAST) begin
            coin5_req_r  <= 1'b0;
            coin10_req_r <= 1'b0;
            jam_r        <= 1'b1;
            rem_r        <= 2'd0;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!hop_ack) begin
            if (rem_r == 2'd0) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_SELECT;
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_FAULT: begin
          rem_r   <= 2'd0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          coin5_req_r  <= 1'b0;
          coin10_req_r <= 1'b0;
          rem_r        <= 2'd0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter STOCK_W, default 8: width of each coin inventory counter.
REQ-002 Parameter INIT5, default 10: number of 5-unit coins loaded at reset.
REQ-003 Parameter INIT10, default 10: number of 10-unit coins loaded at reset.
REQ-004 Parameter ACK_TMO, default 255: number of REQ cycles without hop_ack before the block declares a jam.
REQ-005 The ports SHALL be exactly:
- clk  in  1  Single clock; all logic on rising edge.
- rst  in  1  Asynchronous, active-low reset.
- vend  in  1  One-cycle pulse from the vending FSM: product released.
- change  in  2  Change code, valid with vend: 00 none, 01 five units, 10 ten units, 11 illegal.
- hop_ack  in  1  Hopper acknowledge; a coin has been ejected.
- refill5  in  1  One-cycle pulse: add one 5-unit coin to stock.
- refill10  in  1  One-cycle pulse: add one 10-unit coin to stock.
- clr_jam  in  1  One-cycle pulse: clear the jam flag.
- coin5_req  out  1  Request the hopper to eject one 5-unit coin.
- coin10_req  out  1  Request the hopper to eject one 10-unit coin.
- busy  out  1  Dispense in progress.
- done  out  1  One-cycle pulse: full change amount paid.
- short  out  1  One-cycle pulse: stock insufficient; nothing paid.
- overrun  out  1  One-cycle pulse: vend dropped because the block was busy.
- bad_code  out  1  One-cycle pulse: vend arrived with change=11.
- jam  out  1  Sticky flag: hopper failed to acknowledge within ACK_TMO cycles.
- stock5, stock10  out  STOCK_W  Current coin inventories.

Function
REQ-006 The FSM SHALL have six states: IDLE, SELECT, REQ, RELEASE, DONE, FAULT.
REQ-007 In IDLE, vend=1 with change 01 or 10 SHALL latch rem = 1 or 2 (in 5-unit units) and move to SELECT; busy SHALL be 1 from the next cycle until IDLE is re-entered.
REQ-008 In IDLE, vend with change=00 SHALL be ignored; vend with change=11 SHALL pulse bad_code one cycle later and stay in IDLE.
REQ-009 A vend arriving in any state other than IDLE SHALL be dropped, and overrun SHALL pulse one cycle later.
REQ-010 SELECT feasibility check, before the first coin only: rem=2 needs stock10>=1 or stock5>=2; rem=1 needs stock5>=1; if infeasible, go to FAULT.
REQ-011 SELECT coin choice: if rem=2 and stock10>0, request a 10-unit coin; otherwise request a 5-unit coin; then go to REQ.
REQ-012 In REQ, exactly one of coin5_req/coin10_req SHALL be held high until the cycle hop_ack=1 is sampled.
REQ-013 On that sampled ack, the block SHALL drop the request, decrement the matching stock, subtract the coin value from rem, and go to RELEASE.
REQ-014 RELEASE SHALL wait for hop_ack=0, then go to DONE if rem=0, else to SELECT.
REQ-015 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-016 FAULT SHALL pulse short for one cycle, then go to IDLE with no stock change.
REQ-017 If ACK_TMO consecutive REQ cycles pass without hop_ack, the block SHALL drop the request, set jam, and go to IDLE with no decrement; a partial payout SHALL stand.
REQ-018 While jam=1, vend SHALL be treated as infeasible (short pulse); clr_jam SHALL clear jam, and jam SHALL take priority if jam set and clr_jam occur together.
REQ-019 Refill SHALL saturate at 2^STOCK_W-1; a refill and a decrement of the same counter in one cycle SHALL leave it unchanged.
REQ-020 Decrement SHALL never underflow, which is guaranteed by REQ-010.

Reset
REQ-021 rst=0 SHALL force IDLE, all request/pulse outputs 0, jam=0, rem=0, stock5=INIT5, stock10=INIT10, immediately and asynchronously, including mid-handshake.
REQ-022 Release of rst SHALL be synchronised; the first state change SHALL occur no earlier than the second rising edge after release.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, the change-code constants (NONE, FIVE, TEN, ILLEGAL), and the coin value constants.
REQ-024 The block SHALL contain one sub-module, stock_counter (saturating up/down counter with load value), instantiated twice.

Verification
REQ-025 Reset, then vend with change=10 and stock10=10: coin10_req high; ack after 3 cycles -> stock10=9, done pulse, busy low.
REQ-026 stock10=0, stock5=3, vend with change=10: two coin5 handshakes -> stock5=1, one done pulse.
REQ-027 stock10=0, stock5=1, vend with change=10: short pulse, no request, stocks unchanged.
REQ-028 Hopper never acks, ACK_TMO=255: request drops at REQ cycle 255, jam=1, next vend -> short; clr_jam -> jam=0.
REQ-029 vend during busy -> overrun pulse, single payout; change=11 -> bad_code pulse only.
REQ-030 refill5 in the same cycle as a coin5 ack -> stock5 unchanged; rst asserted during REQ -> coin5_req=0 immediately, stocks = INIT values.
